// File: rtl/bch_chien_search_pkg.sv
// Shared BCH definitions: pointer tag type, search FSM states and GF(2^m) helpers.
// The helpers are usable both for elaboration-time constants and as runtime logic.
package bch_chien_search_pkg;

  localparam int PTR_W = 4;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {WAIT, SEARCH} state_t;

  function automatic int clogb2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction

  // Shift-and-add multiply, reducing by irrpol each time bit m appears.
  function automatic int gf_mult(input int a, input int b, input int m, input int irrpol);
    int r, x;
    r = 0;
    x = a;
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) r ^= x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x ^= irrpol;
    end
    return r;
  endfunction

  function automatic int gf_pow(input int e, input int m, input int irrpol);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = gf_mult(r, 2, m, irrpol);
    return r;
  endfunction

endpackage

// File: rtl/bch_chien_search_if.sv
// Locator-polynomial input bundle and per-position error output bundle.
interface bch_chien_search_if #(
  parameter int m     = 4,
  parameter int t     = 3,
  parameter int cnt_w = 2
);
  import bch_chien_search_pkg::*;

  logic                  iloc_poly_val;
  logic [0:t][m-1:0]     iloc_poly;
  ptr_t                  iloc_poly_ptr;
  logic                  iloc_decfail;
  logic                  obusy;
  logic                  oerr_val;
  logic                  oerr_sop;
  logic                  oerr_eop;
  logic                  oerr;
  ptr_t                  oerr_ptr;
  logic [cnt_w-1:0]      oerr_cnt;
  logic                  odecfail;

  modport master (
    output iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_decfail,
    input  obusy, oerr_val, oerr_sop, oerr_eop, oerr, oerr_ptr, oerr_cnt, odecfail
  );

  modport slave (
    input  iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_decfail,
    output obusy, oerr_val, oerr_sop, oerr_eop, oerr, oerr_ptr, oerr_cnt, odecfail
  );
endinterface

// File: rtl/bch_chien_search_cell.sv
// One locator coefficient register: loads Lambda_j times a fixed init power,
// then multiplies by the fixed step constant alpha^j on every search step.
module bch_chien_cell
  import bch_chien_search_pkg::*;
#(
  parameter int m      = 4,
  parameter int irrpol = 19,
  parameter int INIT_C = 1,
  parameter int STEP_C = 1
)(
  input  logic         iclk,
  input  logic         iload,
  input  logic         istep,
  input  logic [m-1:0] idata,
  output logic [m-1:0] oreg
);

  always_ff @(posedge iclk) begin
    if (iload)      oreg <= m'(gf_mult(int'(idata), INIT_C, m, irrpol));
    else if (istep) oreg <= m'(gf_mult(int'(oreg), STEP_C, m, irrpol));
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates the error locator at every codeword position, emitting
// one flip strobe per position in transmission order plus root count and failure.
module bch_chien_search
  import bch_chien_search_pkg::*;
#(
  parameter int m      = 4,
  parameter int k_max  = 5,
  parameter int d      = 7,
  parameter int n      = 15,
  parameter int irrpol = 19
)(
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  bch_chien_search_if.slave   bus
);

  localparam int t     = (d - 1) / 2;
  localparam int gf_n  = (1 << m) - 1;
  localparam int CNT_W = clogb2(t + 1);
  localparam int POS_W = clogb2(n);

  typedef logic [m-1:0] data_t;

  if (n > gf_n || k_max >= n) begin : g_param_chk
    $error("bch_chien_search: inconsistent code parameters");
  end

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [1:0]       vld_pipe;
  logic             s1_sop, s1_eop, s1_hit;
  ptr_t             ptr_lat;
  logic             dec_lat;
  logic [CNT_W-1:0] deg_lat, deg, cnt_nxt;
  data_t [t:0]      cell_q;
  data_t            sum;
  logic             accept, step;

  // A new polynomial may slip in while the final beat is on the outputs.
  assign accept = iclkena && bus.iloc_poly_val && (state == WAIT) &&
                  (!bus.obusy || bus.oerr_eop);
  assign step   = iclkena && (state == SEARCH);

  always_comb begin
    deg = '0;
    for (int j = 1; j <= t; j++)
      if (bus.iloc_poly[j] != '0) deg = CNT_W'(j);
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j <= t; j++) sum ^= cell_q[j];
  end

  // Init power starts the sweep at position n-1 of a possibly shortened code.
  for (genvar j = 0; j <= t; j++) begin : g_cell
    localparam int INIT_C = gf_pow((j * (gf_n - n + 1)) % gf_n, m, irrpol);
    localparam int STEP_C = gf_pow(j, m, irrpol);
    bch_chien_cell #(
      .m(m), .irrpol(irrpol), .INIT_C(INIT_C), .STEP_C(STEP_C)
    ) u_cell (
      .iclk  (iclk),
      .iload (accept),
      .istep (step),
      .idata (bus.iloc_poly[j]),
      .oreg  (cell_q[j])
    );
  end

  always_comb begin
    cnt_nxt = s1_sop ? '0 : bus.oerr_cnt;
    if (s1_hit && cnt_nxt != '1) cnt_nxt = cnt_nxt + CNT_W'(1);
  end

  always_ff @(posedge iclk) begin
    if (accept) begin
      ptr_lat <= bus.iloc_poly_ptr;
      dec_lat <= bus.iloc_decfail || (bus.iloc_poly[0] == '0);
      deg_lat <= deg;
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state        <= WAIT;
      pos          <= '0;
      vld_pipe     <= '0;
      s1_sop       <= 1'b0;
      s1_eop       <= 1'b0;
      s1_hit       <= 1'b0;
      bus.obusy    <= 1'b0;
      bus.oerr_sop <= 1'b0;
      bus.oerr_eop <= 1'b0;
      bus.oerr     <= 1'b0;
      bus.oerr_cnt <= '0;
      bus.odecfail <= 1'b0;
    end else if (iclkena) begin
      case (state)
        WAIT: if (accept) begin
          state <= SEARCH;
          pos   <= POS_W'(n - 1);
        end
        SEARCH: begin
          if (pos == '0) state <= WAIT;
          pos <= pos - POS_W'(1);
        end
        default: state <= WAIT;
      endcase
      vld_pipe     <= {vld_pipe[0], state == SEARCH};
      s1_sop       <= (state == SEARCH) && (pos == POS_W'(n - 1));
      s1_eop       <= (state == SEARCH) && (pos == '0);
      s1_hit       <= (sum == '0);
      bus.oerr_sop <= vld_pipe[0] && s1_sop;
      bus.oerr_eop <= vld_pipe[0] && s1_eop;
      bus.oerr     <= vld_pipe[0] && s1_hit;
      if (vld_pipe[0]) bus.oerr_cnt <= cnt_nxt;
      bus.odecfail <= vld_pipe[0] && s1_eop && (dec_lat || (cnt_nxt != deg_lat));
      if (accept)                             bus.obusy <= 1'b1;
      else if (vld_pipe[1] && bus.oerr_eop)   bus.obusy <= 1'b0;
    end
  end

  assign bus.oerr_val = vld_pipe[1];
  assign bus.oerr_ptr = ptr_lat;

endmodule
